// File: rtl/rms_sumsq_feeder.sv
// Streaming sum-of-squares front end for the RMS-norm path: squares and accumulates
// VEC_LEN signed samples, then hands the mean of squares to the sqrt unit.
module rms_sumsq_feeder #(
  parameter int DATA_W   = 9,
  parameter int VEC_LEN  = 8,
  parameter int LOG2_LEN = $clog2(VEC_LEN),
  parameter int RAD_W    = 2*DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              sqrt_busy,
  output logic              sqrt_start,
  output logic [RAD_W-1:0]  sqrt_rad,
  output logic              err_len
);

  localparam int ACC_W = RAD_W + LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] LAST_CNT = LOG2_LEN'(VEC_LEN - 1);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_LEN-1:0] cnt_q, cnt_d;
  logic                pend_valid_q, pend_valid_d;
  logic [RAD_W-1:0]    pend_data_q, pend_data_d;
  logic                issued_q, issued_d;
  logic [RAD_W-1:0]    rad_q, rad_d;
  logic                err_len_q, err_len_d;

  logic signed [DATA_W-1:0]   data_s;
  logic signed [2*DATA_W-1:0] sq_s;
  logic [ACC_W-1:0]           sum_s;
  logic                       issue_s;
  logic                       beat_s;
  logic                       final_s;

  // (-2^(DATA_W-1))^2 still fits the 2*DATA_W result as a non-negative value
  assign data_s  = $signed(in_data);
  assign sq_s    = data_s * data_s;
  assign sum_s   = acc_q + {{LOG2_LEN{1'b0}}, sq_s};

  // issued_q masks the cycle before the sqrt unit's busy flag rises
  assign issue_s = pend_valid_q && !sqrt_busy && !issued_q;
  assign in_ready   = !pend_valid_q || issue_s;
  assign beat_s     = in_valid && in_ready;
  assign final_s    = (cnt_q == LAST_CNT);
  assign sqrt_start = issue_s;
  assign sqrt_rad   = issue_s ? pend_data_q : rad_q;
  assign err_len    = err_len_q;

  // Next-state logic for accumulation, pending buffer and issue bookkeeping
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    issued_d     = issue_s;
    rad_d        = rad_q;
    err_len_d    = 1'b0;
    if (issue_s) begin
      pend_valid_d = 1'b0;
      rad_d        = pend_data_q;
    end else begin
      rad_d        = rad_q;
    end
    // a final beat on the issue edge refills the buffer, so set wins over clear
    if (beat_s) begin
      err_len_d = (in_last != final_s);
      if (final_s) begin
        pend_data_d  = sum_s[LOG2_LEN +: RAD_W];
        pend_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + LOG2_LEN'(1);
      end
    end else begin
      err_len_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      issued_q     <= 1'b0;
      rad_q        <= '0;
      err_len_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      issued_q     <= issued_d;
      rad_q        <= rad_d;
      err_len_q    <= err_len_d;
    end
  end

endmodule

// File: doc/rms_sumsq_feeder.md
Name: rms_sumsq_feeder

Overview:
- Streaming front end of the RMS-norm path. Accepts a vector of VEC_LEN signed samples, one per handshake beat.
- Squares and accumulates the samples, then forms the mean of squares.
- Hands the mean to the iterative sqrt unit as its radicand, with a one-cycle start pulse.
- A one-entry pending buffer lets the next vector accumulate while sqrt is still busy.

Parameters:
- DATA_W, 9: sample width, signed two's complement.
- VEC_LEN, 8: samples per vector; must be a power of 2 and at least 2.
- LOG2_LEN, $clog2(VEC_LEN): derived; do not override.
- RAD_W, 2*DATA_W: radicand width presented to sqrt (sqrt WIDTH must equal this).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  signed sample.
- in_last  in  1  producer's end-of-vector marker; checked only, never used for control.
- sqrt_busy  in  1  busy output of the sqrt unit.
- sqrt_start  out  1  start pulse to sqrt.
- sqrt_rad  out  RAD_W  radicand to sqrt; valid while sqrt_start=1.
- err_len  out  1  one-cycle pulse on a vector-length mismatch.

Behaviour:
- Reset: acc=0, cnt=0, pend_valid=0, pend_data=0, sqrt_start=0, sqrt_rad=0, err_len=0, in_ready=1 once reset deasserts. Reset mid-vector discards the partial sum and any pending mean.
- Beat: accepted when in_valid && in_ready at the clock edge.
- Square: sq = in_data*in_data computed signed, result unsigned in 2*DATA_W bits. (-2^(DATA_W-1))^2 fits.
- Accumulator: acc is 2*DATA_W+LOG2_LEN bits wide and cannot overflow.
- Non-final beat (cnt != VEC_LEN-1): acc += sq, cnt += 1.
- Final beat (cnt == VEC_LEN-1):
  - pend_data <= (acc+sq) >> LOG2_LEN (floor; truncated to RAD_W, which is lossless).
  - pend_valid <= 1, acc <= 0, cnt <= 0.
- Issue, combinational: issue = pend_valid && !sqrt_busy && !issued_q.
  - issued_q is a 1-cycle register that masks the cycle before sqrt's busy rises.
  - sqrt_start = issue; sqrt_rad = pend_data when issue=1, else holds its last value.
  - On an issue edge: pend_valid <= 0, issued_q <= 1. issued_q clears the next cycle.
- in_ready = !pend_valid || issue. This contains a combinational path from sqrt_busy.
- Simultaneous issue and final beat on the same edge: the new mean overwrites pend_data and pend_valid stays 1 (set wins over clear).
- While pend_valid=1 and sqrt is busy, the block accepts no beats. Backpressure holds until sqrt_busy falls.
- Latency, idle sqrt: final beat at edge N gives sqrt_start=1 during cycle N+1. sqrt accepts at edge N+2.
- Length check: on every accepted beat, err_len <= (in_last != (cnt==VEC_LEN-1)). It is a single-cycle pulse; accumulation and cnt are unaffected.
- in_valid without in_ready: in_data is ignored and no state changes.
- sqrt_busy must be defined at the top level (the sqrt unit has no reset). The integration must hold sqrt_busy=0 until the first start.

Test Plan:
- Idle sqrt, eight beats of 3 with in_last on beat 8 -> sqrt_start=1 exactly one cycle after the last beat, sqrt_rad=9, err_len never pulses.
- Eight beats of -256 -> sqrt_rad=65536 (0x10000), no overflow.
- Beats 1..8 -> sum 204, sqrt_rad=25 (floor of 25.5).
- sqrt_busy held high, two full vectors back-to-back:
  - First mean pends; second vector's final beat is accepted only after the issue.
  - in_ready=0 while the pend is full and busy=1.
  - After busy falls, start issues on the next cycle and in_ready=1 in that same cycle.
- in_last asserted on beat 4 and absent on beat 8 of an all-2 vector -> err_len pulses after beat 4 and after beat 8; sqrt_rad=4 is still issued after beat 8.
- rst pulsed asynchronously mid-clock after 5 beats -> outputs clear immediately. A following 8-beat vector of 1 gives sqrt_rad=1.
